cam_capture_scaler: RTL and testbench

Parametrised camera-capture front end for the OV7670 path, the successor to the fixed 640x480 RGB capture stage. It runs in the camera `pclk` domain, assembles two-byte pixels from the 8-bit camera bus, reduces each pixel to a configurable colour depth, and can decimate 2:1 in both axes. It drives the write port of the dual-clock frame buffer (address, data, write enable), and adds frame arming, frame counting and overflow reporting.

---
 rtl/cam_capture_scaler.sv | 172 +++++++++++++++++
 tb/tb_cam_capture_scaler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_scaler.sv
// OV7670 capture front end: pairs camera bytes into pixels, reduces colour depth, optionally
// decimates 2:1 and writes the frame buffer. Define CAM_GRAY_EN to enable YUV422 luma capture.
module cam_capture_scaler #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CH_BITS  = 3,
   parameter int ADDR_W   = 19
) (
   input  logic                   pclk,
   input  logic                   reset_n,
   input  logic [7:0]             pixel,
   input  logic                   href,
   input  logic                   cam_vsync,
   input  logic                   capture_en,
   input  logic                   decim,
   input  logic                   mode,
   output logic                   wren,
   output logic [ADDR_W-1:0]      wraddress,
   output logic [3*CH_BITS-1:0]   write_data,
   output logic                   frame_done,
   output logic [7:0]             frame_count,
   output logic                   overflow
);

   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);
   localparam int DW = 3 * CH_BITS;
   localparam logic [XW-1:0]     X_MAX  = XW'(H_ACTIVE);
   localparam logic [YW-1:0]     Y_MAX  = YW'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] H_FULL = ADDR_W'(H_ACTIVE);
   localparam logic [ADDR_W-1:0] H_HALF = ADDR_W'(H_ACTIVE / 2);

   typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_FRAME, CAPTURE} state_t;

   state_t              state, state_nx;
   logic                href_q, vs_q;
   logic                phase;
   logic [7:0]          byte0;
   logic [XW-1:0]       x;
   logic [YW-1:0]       y;
   logic                decim_r;
   logic                vs_rise, vs_fall;
   logic                frame_start, frame_end;
   logic                capture_act, pix_stb, in_bounds, keep, wr_now, ovf_now;
   logic [ADDR_W-1:0]   addr_nx;
   logic [DW-1:0]       data_nx;

   function automatic logic [DW-1:0] rgb_reduce(input logic [7:0] b0, input logic [7:0] b1);
      logic [4:0] r, b;
      logic [5:0] g;
      r = b0[7:3];
      g = {b0[2:0], b1[7:5]};
      b = b1[4:0];
      return {r[4 -: CH_BITS], g[5 -: CH_BITS], b[4 -: CH_BITS]};
   endfunction

`ifdef CAM_GRAY_EN
   logic mode_r;

   function automatic logic [DW-1:0] gray_reduce(input logic [7:0] luma);
      return {3{luma[7 -: CH_BITS]}};
   endfunction
`else
   logic unused_mode;
   assign unused_mode = mode;
`endif

   assign vs_rise = cam_vsync & ~vs_q;
   assign vs_fall = ~cam_vsync & vs_q;

   always_ff @(posedge pclk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state)
         IDLE:       if (capture_en) state_nx = WAIT_VS;
         WAIT_VS:    if (cam_vsync) state_nx = WAIT_FRAME;
         WAIT_FRAME: if (vs_fall) begin
            frame_start = 1'b1;
            state_nx    = CAPTURE;
         end
         CAPTURE:    if (vs_rise) begin
            frame_end = 1'b1;
            state_nx  = capture_en ? WAIT_FRAME : IDLE;
         end
         default:    state_nx = IDLE;
      endcase
   end

   // a vsync rise in the same cycle as a byte ends the frame and drops that byte
   assign capture_act = (state == CAPTURE) && !vs_rise;
   assign pix_stb     = capture_act && href && phase;
   assign in_bounds   = (x < X_MAX) && (y < Y_MAX);
   assign keep        = decim_r ? (!x[0] && !y[0]) : 1'b1;
   assign wr_now      = pix_stb && in_bounds && keep;
   assign ovf_now     = pix_stb && !in_bounds;
   assign addr_nx     = decim_r ? (ADDR_W'(x[XW-1:1]) + H_HALF * ADDR_W'(y[YW-1:1]))
                                : (ADDR_W'(x) + H_FULL * ADDR_W'(y));

`ifdef CAM_GRAY_EN
   assign data_nx = mode_r ? gray_reduce(byte0) : rgb_reduce(byte0, pixel);
`else
   assign data_nx = rgb_reduce(byte0, pixel);
`endif

   always_ff @(posedge pclk) begin
      if (capture_act && href && !phase) byte0 <= pixel;
   end

   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         href_q      <= 1'b0;
         vs_q        <= 1'b0;
         phase       <= 1'b0;
         x           <= '0;
         y           <= '0;
         decim_r     <= 1'b0;
         wren        <= 1'b0;
         wraddress   <= '0;
         write_data  <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         overflow    <= 1'b0;
`ifdef CAM_GRAY_EN
         mode_r      <= 1'b0;
`endif
      end else begin
         href_q     <= href;
         vs_q       <= cam_vsync;
         wren       <= wr_now;
         frame_done <= frame_end;
         if (wr_now) begin
            wraddress  <= addr_nx;
            write_data <= data_nx;
         end
         if (frame_end) frame_count <= frame_count + 8'd1;
         if (frame_start) begin
            phase    <= 1'b0;
            x        <= '0;
            y        <= '0;
            overflow <= 1'b0;
            decim_r  <= decim;
`ifdef CAM_GRAY_EN
            mode_r   <= mode;
`endif
         end else if (capture_act) begin
            if (href) begin
               phase <= ~phase;
               if (phase) begin
                  if (x != X_MAX) x <= x + 1'b1;
                  if (ovf_now) overflow <= 1'b1;
               end
            end else begin
               // odd trailing byte is discarded by clearing phase while href is low
               phase <= 1'b0;
               if (href_q && x != '0) begin
                  x <= '0;
                  if (y != Y_MAX) y <= y + 1'b1;
               end
            end
         end else begin
            phase <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cam_capture_scaler.sv
// Randomized scoreboard bench for cam_capture_scaler on a reduced 12x8 frame.
module tb_cam_capture_scaler;

   localparam int H  = 12;
   localparam int V  = 8;
   localparam int CH = 3;
   localparam int AW = 7;
   localparam int DW = 3 * CH;
`ifdef CAM_GRAY_EN
   localparam bit GRAY = 1'b1;
`else
   localparam bit GRAY = 1'b0;
`endif

   logic          pclk = 1'b0;
   logic          reset_n;
   logic [7:0]    pixel;
   logic          href;
   logic          cam_vsync;
   logic          capture_en;
   logic          decim;
   logic          mode;
   logic          wren;
   logic [AW-1:0] wraddress;
   logic [DW-1:0] write_data;
   logic          frame_done;
   logic [7:0]    frame_count;
   logic          overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_addr_q[$];
   int exp_data_q[$];
   int exp_fc_q[$];
   int exp_count = 0;
   int last_addr = -1;

   cam_capture_scaler #(
      .H_ACTIVE(H), .V_ACTIVE(V), .CH_BITS(CH), .ADDR_W(AW)
   ) dut (
      .pclk(pclk), .reset_n(reset_n), .pixel(pixel), .href(href),
      .cam_vsync(cam_vsync), .capture_en(capture_en), .decim(decim), .mode(mode),
      .wren(wren), .wraddress(wraddress), .write_data(write_data),
      .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // Expected buffer word for a byte pair, from the colour rules in plain arithmetic
   function automatic int exp_pixel(input int b0, input int b1, input bit md);
      int r, g, b, yv;
      if (md && GRAY) begin
         yv = b0 >> (8 - CH);
         return (yv << (2 * CH)) | (yv << CH) | yv;
      end
      r = b0 >> 3;
      g = (b0 % 8) * 8 + (b1 >> 5);
      b = b1 % 32;
      return ((r >> (5 - CH)) << (2 * CH)) | ((g >> (6 - CH)) << CH) | (b >> (5 - CH));
   endfunction

   function automatic int gen_byte(input int pat, input bit first);
      if (pat == 1) return first ? 'hF8 : 'h1F;
      if (pat == 2 && first) return 'hE0;
      return int'($urandom_range(0, 255));
   endfunction

   // One frame: vsync high, fall, lines, vsync rise. Model pushes expected writes as bytes go out.
   task automatic run_frame(input int nlines, input int nbytes, input int odd_line,
                            input int odd_bytes, input bit dcm, input bit md, input int pat,
                            input bit cap_in, input int disarm_line, input int reset_line);
      bit cap = cap_in;
      bit ovf = 1'b0;
      int ly  = 0;
      int nb, px, b0, bv;
      decim = dcm;
      mode  = md;
      href  = 1'b0;
      cam_vsync = 1'b1;
      repeat (4) tick();
      cam_vsync = 1'b0;
      repeat (2) tick();
      if (cap) check("overflow_cleared", 32'(overflow), 32'(0));
      for (int l = 0; l < nlines; l++) begin
         nb = (l == odd_line) ? odd_bytes : nbytes;
         px = 0;
         b0 = 0;
         if (l == disarm_line) capture_en = 1'b0;
         for (int i = 0; i < nb; i++) begin
            bv    = gen_byte(pat, (i % 2) == 0);
            href  = 1'b1;
            pixel = 8'(bv);
            if (i % 2 == 0) begin
               b0 = bv;
            end else begin
               if (cap) begin
                  if (px < H && ly < V) begin
                     if (!dcm || (px % 2 == 0 && ly % 2 == 0)) begin
                        exp_addr_q.push_back(dcm ? (px / 2 + (H / 2) * (ly / 2)) : (px + H * ly));
                        exp_data_q.push_back(exp_pixel(b0, bv, md));
                     end
                  end else begin
                     ovf = 1'b1;
                  end
               end
               px++;
            end
            if (l == reset_line && i == 4) reset_n = 1'b0;
            tick();
            if (reset_n == 1'b0) begin
               reset_n = 1'b1;
               check("rst_wren", 32'(wren), 32'(0));
               check("rst_wraddress", 32'(wraddress), 32'(0));
               check("rst_write_data", 32'(write_data), 32'(0));
               check("rst_frame_done", 32'(frame_done), 32'(0));
               check("rst_frame_count", 32'(frame_count), 32'(0));
               check("rst_overflow", 32'(overflow), 32'(0));
               cap = 1'b0;
               exp_count = 0;
            end
         end
         href = 1'b0;
         if (px > 0) ly++;
         repeat (3) tick();
      end
      repeat (2) tick();
      if (cap) begin
         exp_count = (exp_count + 1) % 256;
         exp_fc_q.push_back(exp_count);
      end
      cam_vsync = 1'b1;
      repeat (4) tick();
      check("pending_writes", 32'(exp_addr_q.size()), 32'(0));
      check("pending_frame_done", 32'(exp_fc_q.size()), 32'(0));
      check("frame_count", 32'(frame_count), 32'(exp_count));
      if (cap) check("overflow_flag", 32'(overflow), 32'(ovf));
   endtask

   always @(negedge pclk) begin : monitor
      int ea, ed, ef;
      if (wren === 1'b1) begin
         if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                     wraddress, write_data);
         end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            check("wr_addr", 32'(wraddress), 32'(ea));
            check("wr_data", 32'(write_data), 32'(ed));
         end
         last_addr = int'(wraddress);
      end
      if (frame_done === 1'b1) begin
         if (exp_fc_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame_done: got count %0d, expected no pulse", frame_count);
         end else begin
            ef = exp_fc_q.pop_front();
            check("done_count", 32'(frame_count), 32'(ef));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got time limit, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n    = 1'b0;
      pixel      = 8'h00;
      href       = 1'b0;
      cam_vsync  = 1'b0;
      capture_en = 1'b0;
      decim      = 1'b0;
      mode       = 1'b0;
      repeat (3) tick();
      check("init_wren", 32'(wren), 32'(0));
      check("init_wraddress", 32'(wraddress), 32'(0));
      check("init_write_data", 32'(write_data), 32'(0));
      check("init_frame_done", 32'(frame_done), 32'(0));
      check("init_frame_count", 32'(frame_count), 32'(0));
      check("init_overflow", 32'(overflow), 32'(0));
      reset_n = 1'b1;
      tick();

      capture_en = 1'b1;
      // full-scale fixed F8/1F pattern
      run_frame(V, 2 * H, -1, 0, 1'b0, 1'b0, 1, 1'b1, -1, -1);
      check("last_addr_full", 32'(last_addr), 32'(H * V - 1));
      // full-scale random data
      run_frame(V, 2 * H, -1, 0, 1'b0, 1'b0, 0, 1'b1, -1, -1);
      // decimated random data
      run_frame(V, 2 * H, -1, 0, 1'b1, 1'b0, 0, 1'b1, -1, -1);
      check("last_addr_decim", 32'(last_addr), 32'((H / 2) * (V / 2) - 1));
      // one over-long line and one extra line
      run_frame(V + 1, 2 * H, 0, 2 * H + 2, 1'b0, 1'b0, 0, 1'b1, -1, -1);
      // normal frame after overflow
      run_frame(V, 2 * H, -1, 0, 1'b0, 1'b0, 0, 1'b1, -1, -1);
      // line 2 carries only three bytes
      run_frame(V, 2 * H, 2, 3, 1'b0, 1'b0, 0, 1'b1, -1, -1);
      // luma pattern with mode=1
      run_frame(V, 2 * H, -1, 0, 1'b0, 1'b1, 2, 1'b1, -1, -1);
      // disarm mid-frame, frame still completes
      run_frame(V, 2 * H, -1, 0, 1'b0, 1'b0, 0, 1'b1, 3, -1);
      // disarmed: no writes, no frame_done
      run_frame(V, 2 * H, -1, 0, 1'b0, 1'b0, 0, 1'b0, -1, -1);
      capture_en = 1'b1;
      // reset pulse in the middle of line 2
      run_frame(V, 2 * H, -1, 0, 1'b0, 1'b0, 0, 1'b1, -1, 2);
      // first capture after that reset
      run_frame(V, 2 * H, -1, 0, 1'b1, 1'b0, 0, 1'b1, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
